// File: rtl/prbs16_pkg.sv
// prbs16_pkg: shared definitions for the PRBS16 generator/checker pair.
//   PRBS_W        width of the sequence shift register
//   TAP_A..TAP_D  polynomial taps x^16 + x^14 + x^13 + x^11 + 1
//   chk_state_e   checker FSM states
package prbs16_pkg;

    localparam int PRBS_W = 16;

    localparam int TAP_A = 16;
    localparam int TAP_B = 14;
    localparam int TAP_C = 13;
    localparam int TAP_D = 11;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/prbs16_next.sv
// prbs16_next: combinational next-bit function of the PRBS16 sequence.
// Shared by the generator and the checker so the two cannot diverge.
// Ports:
//   state_i [PRBS_W-1:0]  in   current shift register, bit 15 oldest, bit 0 newest
//   bit_o                 out  next sequence bit
module prbs16_next
    import prbs16_pkg::*;
(
    input  logic [PRBS_W-1:0] state_i,
    output logic              bit_o
);

    // The all-zero state would otherwise repeat forever; force a 1 to escape it.
    assign bit_o = (state_i == '0) ? 1'b1
                 : (state_i[TAP_A-1] ^ state_i[TAP_B-1] ^ state_i[TAP_C-1] ^ state_i[TAP_D-1]);

endmodule

// File: rtl/prbs16_checker.sv
// prbs16_checker: self-synchronising receive checker for the PRBS16 sequence.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bit_vld    in   bit_in valid strobe; nothing advances when low
//   bit_in     in   received serial bit
//   clr        in   synchronous clear of err_cnt (and bit_cnt)
//   locked     out  1 while the FSM is in LOCKED (this is the state register itself)
//   err_pulse  out  one-cycle pulse per mismatched bit while LOCKED
//   err_cnt    out  saturating count of errors seen while LOCKED
//   bit_cnt    out  (PRBS_CHK_BITCNT_EN only) saturating count of valid bits while LOCKED
// Handshake: bit_vld is a one-way strobe with no back-pressure; every bit
// presented with bit_vld=1 is consumed in that cycle.
// Build option: define PRBS_CHK_BITCNT_EN to add the bit_cnt port and counter.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_CNT    = 32,
    parameter int LOSS_WIN    = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [15:0]      bit_cnt
`endif
);

    localparam int FILL_W  = $clog2(PRBS_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN);
    // Sized so the window error count can never wrap, whatever the threshold.
    localparam int WERR_W  = $clog2(LOSS_THRESH + LOSS_WIN + 1);

    logic [PRBS_W-1:0]  s_q, s_d;
    chk_state_e         state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  win_err_q, win_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;

    logic               pred;
    logic               mis;
    logic [WERR_W-1:0]  win_err_nxt;

    prbs16_next u_next (
        .state_i (s_q),
        .bit_o   (pred)
    );

    always_comb begin
        s_d         = s_q;
        state_d     = state_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        win_err_d   = win_err_q;
        mis         = 1'b0;
        win_err_nxt = win_err_q;

        if (bit_vld) begin
            case (state_q)
                SEARCH: begin
                    s_d = {s_q[PRBS_W-2:0], bit_in};
                    if (fill_q < FILL_W'(PRBS_W)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (bit_in == pred) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d   = LOCKED;
                            match_d   = '0;
                            win_d     = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so errored input cannot corrupt the reference.
                    s_d = {s_q[PRBS_W-2:0], pred};
                    mis = (bit_in != pred);
                    if (win_q == WIN_W'(LOSS_WIN - 1)) begin
                        // Wrap bit opens the new window; its own error counts there.
                        win_d       = '0;
                        win_err_nxt = WERR_W'(mis);
                    end else begin
                        win_d       = win_q + WIN_W'(1);
                        win_err_nxt = win_err_q + WERR_W'(mis);
                    end
                    win_err_d = win_err_nxt;
                    if (win_err_nxt >= WERR_W'(LOSS_THRESH)) begin
                        state_d   = SEARCH;
                        fill_d    = '0;
                        match_d   = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        err_pulse_d = mis;

        // clr wins over a coincident error: the error still pulses but is not counted.
        if (clr) begin
            err_cnt_d = '0;
        end else if (mis && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            state_q     <= SEARCH;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bit_cnt_q, bit_cnt_d;

    // Deliberately survives loss of lock; only clr and reset clear it.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clr) begin
            bit_cnt_d = '0;
        end else if (bit_vld && (state_q == LOCKED) && (bit_cnt_q != 16'hFFFF)) begin
            bit_cnt_d = bit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs16_checker.sv
// tb_prbs16_checker: self-checking bench for prbs16_checker.
// Two instances: u_dut0 with default parameters, u_dut1 with LOSS_THRESH=65
// for the error-counter saturation sequence.
module tb_prbs16_checker;

    localparam int W = 26;   // {locked, err_pulse, err_cnt[7:0], bit_cnt[15:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       vld0, bit0, clr0, locked0, pulse0;
    logic       vld1, bit1, clr1, locked1, pulse1;
    logic [7:0] cnt0, cnt1;
`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bc0, bc1;
`endif

    prbs16_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .bit_vld(vld0), .bit_in(bit0), .clr(clr0),
        .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_cnt(bc0)
`endif
    );

    prbs16_checker #(.LOSS_THRESH(65)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bit_vld(vld1), .bit_in(bit1), .clr(clr1),
        .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
`ifdef PRBS_CHK_BITCNT_EN
        , .bit_cnt(bc1)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [15:0] s;
        bit          lk;
        int          fill, match, win, werr, ecnt, bcnt;
        bit          pulse;
        int          thresh;
    } mdl_t;
    mdl_t m[2];

    logic [15:0] g;   // reference generator state

    typedef struct {
        bit v, inv, c;
        bit e_lk, e_pulse;
        logic [7:0] e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic prbs_bit(input logic [15:0] s);
        if (s == 16'h0) return 1'b1;
        return s[15] ^ s[13] ^ s[12] ^ s[10];
    endfunction

    task automatic gen_bit(output bit b);
        b = prbs_bit(g);
        g = {g[14:0], b};
    endtask

    task automatic model_reset(input int k, input int th);
        m[k] = '{s:16'h0, lk:1'b0, fill:0, match:0, win:0, werr:0, ecnt:0, bcnt:0, pulse:1'b0, thresh:th};
    endtask

    task automatic model_step(input int k, input bit v, input bit b, input bit c);
        bit e;
        logic p;
        e = 1'b0;
        if (v) begin
            p = prbs_bit(m[k].s);
            if (!m[k].lk) begin
                m[k].s = {m[k].s[14:0], b};
                if (m[k].fill < 16) m[k].fill++;
                else if (b == p) begin
                    m[k].match++;
                    if (m[k].match == 32) begin
                        m[k].lk = 1'b1; m[k].match = 0; m[k].win = 0; m[k].werr = 0;
                    end
                end else m[k].match = 0;
            end else begin
                e = (b != p);
                m[k].s = {m[k].s[14:0], p};
                if (m[k].bcnt < 65535) m[k].bcnt++;
                if (m[k].win == 63) begin
                    m[k].win = 0; m[k].werr = int'(e);
                end else begin
                    m[k].win++; m[k].werr += int'(e);
                end
                if (m[k].werr >= m[k].thresh) begin
                    m[k].lk = 1'b0; m[k].fill = 0; m[k].match = 0; m[k].win = 0; m[k].werr = 0;
                end
            end
        end
        m[k].pulse = e;
        if (c) begin
            m[k].ecnt = 0; m[k].bcnt = 0;
        end else if (e && m[k].ecnt < 255) m[k].ecnt++;
    endtask

    function automatic logic [W-1:0] model_vec(input int k);
        logic [15:0] bc;
`ifdef PRBS_CHK_BITCNT_EN
        bc = 16'(m[k].bcnt);
`else
        bc = 16'h0;
`endif
        return {m[k].lk, m[k].pulse, 8'(m[k].ecnt), bc};
    endfunction

    function automatic logic [W-1:0] dut_vec(input int k);
        logic [15:0] bc;
`ifdef PRBS_CHK_BITCNT_EN
        bc = (k == 0) ? bc0 : bc1;
`else
        bc = 16'h0;
`endif
        return (k == 0) ? {locked0, pulse0, cnt0, bc} : {locked1, pulse1, cnt1, bc};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input int k, input bit v, input bit b, input bit c);
        logic [W-1:0] e;
        if (k == 0) begin
            vld0 = v; bit0 = b; clr0 = c; vld1 = 1'b0; bit1 = 1'b0; clr1 = 1'b0;
        end else begin
            vld1 = v; bit1 = b; clr1 = c; vld0 = 1'b0; bit0 = 1'b0; clr0 = 1'b0;
        end
        model_step(k, v, b, c);
        exp_q.push_back(model_vec(k));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check((k == 0) ? "sb_dut0" : "sb_dut1", dut_vec(k), e);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        vld0 = 1'b0; bit0 = 1'b0; clr0 = 1'b0;
        vld1 = 1'b0; bit1 = 1'b0; clr1 = 1'b0;
        model_reset(0, 8);
        model_reset(1, 65);
        exp_q.delete();
        #1;
        check("rst_dut0", dut_vec(0), '0);
        check("rst_dut1", dut_vec(1), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vt[9];
        bit b;
        int nv;

        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};  // gap clears err_pulse
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};  // clr beats coincident error
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};

        g = 16'hACE1;
        apply_reset();

        // 1: clean stream locks after exactly 48 bits
        for (int i = 1; i <= 200; i++) begin
            gen_bit(b);
            step(0, 1'b1, b, 1'b0);
            if (i == 47) check("t1_not_locked_47", W'(locked0), W'(1'b0));
            if (i == 48) check("t1_locked_48", W'(locked0), W'(1'b1));
        end
        check("t1_err_cnt", W'(cnt0), W'(0));

        // 2: table of single errors, gaps and clr while locked
        for (int i = 0; i < 9; i++) begin
            if (vt[i].v) gen_bit(b);
            else b = 1'($urandom_range(0, 1));
            step(0, vt[i].v, b ^ vt[i].inv, vt[i].c);
            check($sformatf("tbl_%0d", i), W'({locked0, pulse0, cnt0}),
                  W'({vt[i].e_lk, vt[i].e_pulse, vt[i].e_cnt}));
        end

        // 6: async reset mid-operation, right after an errored bit
        gen_bit(b);
        step(0, 1'b1, ~b, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        gen_bit(b);
        step(0, 1'b1, ~b, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_async_out", W'({locked0, pulse0, cnt0}), W'(0));
`ifdef PRBS_CHK_BITCNT_EN
        check("t6_bitcnt_rst", W'(bc0), W'(0));
`endif
        apply_reset();
        nv = 0;
        for (int i = 0; nv < 48 && i < 200; i++) begin
            if (i % 5 == 4) step(0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            else begin
                gen_bit(b);
                step(0, 1'b1, b, 1'b0);
                nv++;
                if (nv == 47) check("t6_not_locked_47", W'(locked0), W'(1'b0));
            end
        end
        check("t6_relock_48", W'(locked0), W'(1'b1));

        // 3: eight errors in one window drop lock, 48 clean bits relock
        for (int i = 1; i <= 8; i++) begin
            gen_bit(b);
            step(0, 1'b1, ~b, 1'b0);
            if (i == 7) check("t3_still_locked_7", W'(locked0), W'(1'b1));
        end
        check("t3_loss", W'(locked0), W'(1'b0));
        check("t3_err_cnt", W'(cnt0), W'(8));
        for (int i = 1; i <= 48; i++) begin
            gen_bit(b);
            step(0, 1'b1, b, 1'b0);
            if (i == 47) check("t3_not_relocked_47", W'(locked0), W'(1'b0));
        end
        check("t3_relock", W'(locked0), W'(1'b1));
        check("t3_err_cnt_kept", W'(cnt0), W'(8));

        // 4: constant zero input never locks
        apply_reset();
        for (int i = 0; i < 500; i++) step(0, 1'b1, 1'b0, 1'b0);
        check("t4_no_lock", W'({locked0, cnt0}), W'(0));

        // 5: saturation on u_dut1, then clr against a coincident error
        for (int i = 0; i < 48; i++) begin
            gen_bit(b);
            step(1, 1'b1, b, 1'b0);
        end
        check("t5_locked", W'(locked1), W'(1'b1));
        for (int i = 0; i < 300; i++) begin
            gen_bit(b);
            step(1, 1'b1, ~b, 1'b0);
        end
        check("t5_saturated", W'({locked1, cnt1}), W'({1'b1, 8'd255}));
        gen_bit(b);
        step(1, 1'b1, ~b, 1'b1);
        check("t5_clr_err", W'({pulse1, cnt1}), W'({1'b1, 8'd0}));
        gen_bit(b);
        step(1, 1'b1, ~b, 1'b0);
        check("t5_after_clr", W'(cnt1), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
